// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: word size, owner state
// encodings and the store-width encoding carried on *_storeops.
package ram_arb_pkg;

    localparam int WORDSIZE = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam logic [1:0] STORE_WORD = 2'd0;
    localparam logic [1:0] STORE_HALF = 2'd1;
    localparam logic [1:0] STORE_BYTE = 2'd2;

    // A burst limit of 1 still needs a one-bit counter.
    function automatic int cntWidth(input int burstMax);
        return (burstMax > 1) ? $clog2(burstMax) : 1;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Next-owner selection for the RAM arbiter: round-robin on ties from IDLE,
// burst-limited hold while owning, and bubble-free handover on release.
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int CW        = cntWidth(BURST_MAX)
) (
    input  logic [1:0]    i_state,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_last,
    input  logic [CW-1:0] i_burstCnt,
    output logic [1:0]    o_nextState
);

    logic w_burstEnd;

    assign w_burstEnd = (i_burstCnt == CW'(BURST_MAX - 1));

    // i_last names the most recent owner, so a tie goes to the other one.
    always_comb begin
        o_nextState = ST_IDLE;
        case (i_state)
            ST_IDLE: begin
                if (i_req0 && i_req1)
                    o_nextState = i_last ? ST_OWN0 : ST_OWN1;
                else if (i_req0)
                    o_nextState = ST_OWN0;
                else if (i_req1)
                    o_nextState = ST_OWN1;
            end
            ST_OWN0: begin
                if (i_req0)
                    o_nextState = (i_req1 && w_burstEnd) ? ST_OWN1 : ST_OWN0;
                else if (i_req1)
                    o_nextState = ST_OWN1;
            end
            ST_OWN1: begin
                if (i_req1)
                    o_nextState = (i_req0 && w_burstEnd) ? ST_OWN0 : ST_OWN1;
                else if (i_req0)
                    o_nextState = ST_OWN0;
            end
            default: o_nextState = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/ram_arb.sv
// Two-requester arbiter for a single-ported RAM with combinational read data;
// the owner's request is passed straight to the RAM and read data is registered back.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [1:0]          m0_storeops,
    input  logic [WORDSIZE-1:0] m0_addr,
    input  logic [WORDSIZE-1:0] m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [WORDSIZE-1:0] m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [1:0]          m1_storeops,
    input  logic [WORDSIZE-1:0] m1_addr,
    input  logic [WORDSIZE-1:0] m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [WORDSIZE-1:0] m1_rdata,
    output logic [WORDSIZE-1:0] ram_addr,
    output logic [WORDSIZE-1:0] ram_wdata,
    output logic                ram_memread,
    output logic                ram_memwrite,
    output logic [1:0]          ram_storeops,
    input  logic [WORDSIZE-1:0] ram_rdata
);

    localparam int CW = cntWidth(BURST_MAX);

    logic [1:0]          r_state;
    logic                r_last;
    logic [CW-1:0]       r_burstCnt;
    logic                r_rstDone;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic [WORDSIZE-1:0] r_rdata0;
    logic [WORDSIZE-1:0] r_rdata1;
    logic [1:0]          w_nextState;
    logic [1:0]          w_stepState;
    logic                w_acc0;
    logic                w_acc1;
    logic                w_ownerChange;

    ram_arb_pick #(
        .BURST_MAX(BURST_MAX),
        .CW       (CW)
    ) u_pick (
        .i_state    (r_state),
        .i_req0     (m0_req),
        .i_req1     (m1_req),
        .i_last     (r_last),
        .i_burstCnt (r_burstCnt),
        .o_nextState(w_nextState)
    );

    // Holding IDLE for the first edge after release pushes the first grant to the second edge.
    assign w_stepState   = r_rstDone ? w_nextState : r_state;
    assign w_ownerChange = (w_stepState != r_state);
    assign w_acc0        = (r_state == ST_OWN0) && m0_req;
    assign w_acc1        = (r_state == ST_OWN1) && m1_req;

    assign m0_gnt    = (r_state == ST_OWN0);
    assign m1_gnt    = (r_state == ST_OWN1);
    assign m0_rvalid = r_rvalid0;
    assign m1_rvalid = r_rvalid1;
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_burstCnt <= '0;
            r_rstDone  <= 1'b0;
        end else begin
            r_rstDone <= 1'b1;
            r_state   <= w_stepState;
            if (w_ownerChange && (w_stepState == ST_OWN0))
                r_last <= 1'b0;
            else if (w_ownerChange && (w_stepState == ST_OWN1))
                r_last <= 1'b1;
            // Saturates so a lone owner never runs the count past the limit.
            if (w_ownerChange || (w_stepState == ST_IDLE))
                r_burstCnt <= '0;
            else if ((w_acc0 || w_acc1) && (r_burstCnt != CW'(BURST_MAX - 1)))
                r_burstCnt <= r_burstCnt + CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_acc0 && !m0_we;
            r_rvalid1 <= w_acc1 && !m1_we;
            if (w_acc0 && !m0_we)
                r_rdata0 <= ram_rdata;
            if (w_acc1 && !m1_we)
                r_rdata1 <= ram_rdata;
        end
    end

    always_comb begin
        ram_addr     = '0;
        ram_wdata    = '0;
        ram_storeops = '0;
        ram_memread  = 1'b0;
        ram_memwrite = 1'b0;
        if (w_acc0) begin
            ram_addr     = m0_addr;
            ram_wdata    = m0_wdata;
            ram_storeops = m0_storeops;
            ram_memread  = ~m0_we;
            ram_memwrite = m0_we;
        end else if (w_acc1) begin
            ram_addr     = m1_addr;
            ram_wdata    = m1_wdata;
            ram_storeops = m1_storeops;
            ram_memread  = ~m1_we;
            ram_memwrite = m1_we;
        end
    end

endmodule
